// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC-stage state encoding, trap cause codes and
// the reset/exception vectors.
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } pc_state_e;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_EXT      = 2'd1;
    localparam logic [1:0] CAUSE_JR_ALIGN = 2'd2;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0180;

endpackage

// File: rtl/next_pc_unit_npc_select.sv
// Next-PC target computation and priority mux. Purely combinational; the
// caller decides whether the selection is actually committed this cycle.
module npc_select
    import cpu_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic        exc,
    input  logic        branch,
    input  logic [31:0] br_off,
    input  logic        jump,
    input  logic [25:0] jump_idx,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] next_pc,
    output logic        take_trap,
    output logic [1:0]  trap_code
);

    logic [31:0] br_t;
    logic [31:0] j_t;

    assign br_t = pc_plus4 + br_off;
    assign j_t  = {pc_plus4[31:28], jump_idx, 2'b00};

    always_comb begin
        next_pc   = pc_plus4;
        take_trap = 1'b0;
        trap_code = CAUSE_NONE;
        if (exc) begin
            next_pc   = EXC_VECTOR;
            take_trap = 1'b1;
            trap_code = CAUSE_EXT;
        end else if (jr && (jr_addr[1:0] != 2'b00)) begin
            next_pc   = EXC_VECTOR;
            take_trap = 1'b1;
            trap_code = CAUSE_JR_ALIGN;
        end else if (jr) begin
            next_pc = jr_addr;
        end else if (jump) begin
            next_pc = j_t;
        end else if (branch) begin
            next_pc = br_t;
        end
    end

endmodule

// File: rtl/next_pc_unit.sv
// Program-counter stage: holds the architectural PC, runs the BOOT/RUN/TRAP
// sequencer, drives the fetch request and records EPC/cause on traps.
module next_pc_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        branch,
    input  logic [31:0] br_off,
    input  logic        jump,
    input  logic [25:0] jump_idx,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    input  logic        exc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic [31:0] epc,
    output logic [1:0]  cause
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic [1:0]  cause_q, cause_d;

    logic [31:0] sel_pc;
    logic        sel_trap;
    logic [1:0]  sel_code;
    logic        advance;

    assign pc_plus4 = pc_q + 32'd4;

    npc_select u_sel (
        .pc_plus4  (pc_plus4),
        .exc       (exc),
        .branch    (branch),
        .br_off    (br_off),
        .jump      (jump),
        .jump_idx  (jump_idx),
        .jr        (jr),
        .jr_addr   (jr_addr),
        .next_pc   (sel_pc),
        .take_trap (sel_trap),
        .trap_code (sel_code)
    );

    // A fetch is only accepted when memory is ready and the pipe is not held;
    // control inputs are meaningful only on that cycle.
    assign advance = (state_q == RUN) && !stall && imem_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        fetch_valid = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            TRAP: state_d = RUN;
            RUN: begin
                fetch_valid = 1'b1;
                if (advance) begin
                    pc_d = sel_pc;
                    if (sel_trap) begin
                        epc_d   = pc_q;
                        cause_d = sel_code;
                        state_d = TRAP;
                    end
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            epc_q   <= 32'd0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    assign pc    = pc_q;
    assign epc   = epc_q;
    assign cause = cause_q;

endmodule

// File: doc/next_pc_unit.md
# next_pc_unit

Program-counter stage of the CPU. It sits directly downstream of the word-offset left-2 shifter and consumes its output as the branch displacement. It holds the architectural PC and selects the next PC from sequential, branch, jump, jump-register or exception sources. It also drives a valid/ready fetch request toward instruction memory and records EPC and cause on traps.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded by reset
- EXC_VECTOR, 32'h0000_0180, PC loaded on any trap
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- stall  input  1  pipeline hold; blocks PC advance
- imem_ready  input  1  instruction memory accepts the current fetch
- branch  input  1  branch taken (Branch & ALU condition)
- br_off  input  32  already-shifted branch displacement (sign-extended imm << 2)
- jump  input  1  J/JAL
- jump_idx  input  26  instruction [25:0]
- jr  input  1  JR/JALR
- jr_addr  input  32  register target
- exc  input  1  external exception request
- pc  output  32  current PC (registered)
- pc_plus4  output  32  pc + 4 (combinational)
- fetch_valid  output  1  fetch request at address pc
- epc  output  32  PC of the trapping instruction
- cause  output  2  0 none, 1 external, 2 misaligned jr

## Operation
- States: BOOT, RUN, TRAP.
- Reset (async, any time, including mid-fetch): state=BOOT, pc=RESET_PC, epc=0, cause=0, fetch_valid=0.
- BOOT: fetch_valid=0; stall, imem_ready and all control inputs are ignored; next cycle goes to RUN.
- RUN: fetch_valid=1. advance = !stall & imem_ready. No advance means pc holds, fetch_valid stays 1, and the address stays stable.
- TRAP: fetch_valid=0 (one bubble); inputs are ignored; next cycle goes to RUN; pc already equals EXC_VECTOR.
- Targets, all 32-bit and wrapping mod 2^32:
  - seq = pc_plus4
  - br_t = pc_plus4 + br_off
  - j_t = {pc_plus4[31:28], jump_idx, 2'b00}
  - jr_t = jr_addr
- Next-PC priority on an advance cycle in RUN:
  - exc: trap, cause=1
  - jr with jr_addr[1:0]!=0: trap, cause=2
  - jr: jr_t
  - jump: j_t
  - branch: br_t
  - otherwise: seq
- Trap action: epc<=pc, cause<=code, pc<=EXC_VECTOR, state<=TRAP.
- cause and epc hold until the next trap or reset. A non-trap advance does not clear them.
- exc, jr, jump and branch are sampled only on advance cycles. Asserting them while stalled has no effect and they must be held by the source.

## Timing
- Advance in cycle N: the new pc is visible after the rising edge ending N, and pc_plus4 follows combinationally.
- Fetch handshake completes on a cycle with fetch_valid & imem_ready & !stall. One instruction address is accepted per completed handshake.
- imem_ready high with stall high does not count as an accepted fetch. pc is re-presented.
- Trap latency: trap decided in N, then TRAP state in N+1 (fetch_valid=0), then RUN in N+2 with fetch_valid=1 at EXC_VECTOR.
- pc=32'hFFFF_FFFC sequential wraps to 0. A branch with negative br_off below 0 wraps.
- Release of rst_n is synchronous to the next clk edge for state purposes. The first fetch_valid=1 occurs in the second cycle after release (BOOT lasts one cycle).

## Structure
- Shared CPU package (cpu_pkg) holds:
  - state encoding (BOOT=2'd0, RUN=2'd1, TRAP=2'd2)
  - cause codes (CAUSE_NONE, CAUSE_EXT, CAUSE_JR_ALIGN)
  - RESET_PC and EXC_VECTOR defaults
- One natural sub-module: npc_select, the combinational target computation and priority mux. It outputs next_pc, take_trap and trap_code.
- The top level holds the FSM, the pc/epc/cause registers and the handshake logic.

## Test plan
- Reset then imem_ready=1, no control: BOOT for 1 cycle with fetch_valid=0, then pc sequence 0, 4, 8, 12.
- pc=0x100 with branch=1 and br_off=0xFFFF_FFF0 -> pc=0xF4. Same case with stall=1 held 3 cycles -> pc stays 0x100 and fetch_valid stays 1, then advances to 0xF4.
- pc=0x1000_0040 with jump=1 and jump_idx=26'h0000_123 -> pc=0x1000_048C. jump and branch both set -> jump wins.
- jr=1 with jr_addr=0x2002 at pc=0x300 -> epc=0x300, cause=2, pc=0x180, one cycle fetch_valid=0, then fetch at 0x180. jr_addr=0x2000 -> pc=0x2000.
- exc=1 together with jr=1 at pc=0x500 -> cause=1, epc=0x500. imem_ready=0 during RUN -> pc and fetch_valid hold with no trap taken until ready.
- rst_n dropped mid-RUN at pc=0x40 with imem_ready=0 -> immediately pc=0, epc=0, cause=0, fetch_valid=0. After release, pc=0xFFFF_FFFC sequential wraps to 0x0.
